// File: rtl/scene_param_loader.sv
// Loads a 55-byte parameter packet into a shadow bank, verifies its XOR checksum and
// promotes it to the active bank on the next frame boundary so renders see stable values.
module scene_param_loader #(
  parameter int unsigned NBYTES = 55,
  parameter int unsigned AW     = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          update_reg,
  input  logic [5:0]    idx,
  input  logic [7:0]    read_data,
  input  logic          pc_ready,
  input  logic          frame_start,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic          param_valid,
  output logic          commit_pending,
  output logic          commit_pulse,
  output logic          seq_err,
  output logic [7:0]    err_cnt
);

  localparam int unsigned NWORDS   = (NBYTES - 1) / 2;
  localparam logic [5:0]  LAST_IDX = 6'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, PENDING} state_t;

  state_t      state_q, state_d;
  logic [7:0]  chk_q, chk_d;
  logic [5:0]  exp_q, exp_d;
  logic        match_q, match_d;
  logic        pend_q, pend_d;
  logic        valid_q, valid_d;
  logic        seq_q, seq_d;
  logic [7:0]  err_q, err_d;
  logic        pulse_q, pulse_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] shadow_q [NWORDS];
  logic [15:0] active_q [NWORDS];
  logic        shadow_we;
  logic        commit;
  logic        err_inc;
  logic        restart;

  assign restart = update_reg && (idx == 6'd0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A byte with idx 0 restarts the load from any state.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (update_reg) state_d = (idx != exp_q) ? IDLE :
                                           (idx == LAST_IDX) ? CHECK : LOAD;
        CHECK:   if (pc_ready) state_d = match_q ? PENDING : IDLE;
        PENDING: if (frame_start) state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    chk_d     = chk_q;
    exp_d     = exp_q;
    match_d   = match_q;
    pend_d    = pend_q;
    valid_d   = valid_q;
    seq_d     = seq_q;
    pulse_d   = 1'b0;
    shadow_we = 1'b0;
    commit    = 1'b0;
    err_inc   = 1'b0;
    if (restart) begin
      chk_d     = read_data;
      exp_d     = 6'd1;
      pend_d    = 1'b0;
      shadow_we = 1'b1;
      err_inc   = (state_q == LOAD) || (state_q == CHECK);
    end else begin
      case (state_q)
        LOAD: begin
          if (update_reg) begin
            if (idx != exp_q) begin
              seq_d   = 1'b1;
              err_inc = 1'b1;
            end else if (idx == LAST_IDX) begin
              match_d = (read_data == chk_q);
            end else begin
              shadow_we = 1'b1;
              chk_d     = chk_q ^ read_data;
              exp_d     = exp_q + 6'd1;
            end
          end
        end
        CHECK: begin
          if (pc_ready) begin
            pend_d  = match_q;
            err_inc = !match_q;
          end
        end
        PENDING: begin
          if (frame_start) begin
            commit  = 1'b1;
            pulse_d = 1'b1;
            valid_d = 1'b1;
            pend_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    rd_d  = (32'(rd_addr) < NWORDS) ? active_q[rd_addr] : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q   <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      seq_q   <= 1'b0;
      err_q   <= '0;
      pulse_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      chk_q   <= chk_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
      rd_q    <= rd_d;
    end
  end

  // Even byte -> high half, odd byte -> low half; commit copies the whole bank at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NWORDS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (shadow_we) begin
        if (idx[0]) shadow_q[idx[5:1]][7:0]  <= read_data;
        else        shadow_q[idx[5:1]][15:8] <= read_data;
      end
      if (commit) begin
        for (int unsigned k = 0; k < NWORDS; k++) active_q[k] <= shadow_q[k];
      end
    end
  end

  assign rd_data        = rd_q;
  assign param_valid    = valid_q;
  assign commit_pending = pend_q;
  assign commit_pulse   = pulse_q;
  assign seq_err        = seq_q;
  assign err_cnt        = err_q;

endmodule
